// File: rtl/axi_pkg.sv
// ----------------------------------------------------------------------------
// axi_pkg
// Shared AXI-Lite types for the slave's write controller (and the read
// controller that will reuse them).
//   resp_t     : B/R response codes.
//   wr_state_t : write sequencer states.
// ----------------------------------------------------------------------------
package axi_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_W,
      WAIT_AW,
      DECODE,
      MEM_WR,
      RESP
   } wr_state_t;

endpackage

// File: rtl/axi_lite_wr_ctrl_beat_capture.sv
// ----------------------------------------------------------------------------
// beat_capture
// Captures one beat from a receive-channel latch and holds that latch until
// the owning transaction is released.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   strobe_i      : one-cycle capture pulse from the channel latch
//   data_i        : channel payload, valid with strobe_i
//   release_i     : transaction finished; drop hold on the next edge
//   data_o        : registered payload
//   hold_o        : back-pressure to the channel latch
//   accept_o      : strobe taken this cycle (hold was low)
//   viol_o        : strobe arrived while held; beat is discarded
// ----------------------------------------------------------------------------
module beat_capture #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         strobe_i,
   input  logic [W-1:0] data_i,
   input  logic         release_i,
   output logic [W-1:0] data_o,
   output logic         hold_o,
   output logic         accept_o,
   output logic         viol_o
);

   logic [W-1:0] data_q;
   logic         hold_q, hold_d;

   assign accept_o = strobe_i & ~hold_q;
   assign viol_o   = strobe_i &  hold_q;
   assign data_o   = data_q;
   assign hold_o   = hold_q;

   // release_i only occurs while held, so it never collides with accept_o
   always_comb begin
      hold_d = hold_q;
      if (release_i)     hold_d = 1'b0;
      else if (accept_o) hold_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
         hold_q <= 1'b0;
      end else begin
         if (accept_o) data_q <= data_i;
         hold_q <= hold_d;
      end
   end

endmodule

// File: rtl/axi_lite_wr_ctrl.sv
// ----------------------------------------------------------------------------
// axi_lite_wr_ctrl
// AXI-Lite write sequencer: pairs one AW beat with one W beat, performs a
// single memory write and returns the B response.
// Ports:
//   ACLK, ARESETn        : clock, asynchronous active-low reset
//   aw_strobe/aw_addr    : AW latch capture pulse and address
//   aw_hold              : holds the AW latch while a transaction is open
//   w_strobe/w_data      : W latch capture pulse and data
//   w_hold               : holds the W latch while a transaction is open
//   mem_we/addr/wdata    : write request, held until mem_ack or timeout
//   mem_ack              : memory accepted the write
//   BVALID/BREADY/BRESP  : write response channel
//   proto_err            : sticky, a strobe arrived on a held channel
// ----------------------------------------------------------------------------
module axi_lite_wr_ctrl
   import axi_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned MEM_DEPTH   = 16,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              aw_strobe,
   input  logic [ADDR_W-1:0] aw_addr,
   output logic              aw_hold,
   input  logic              w_strobe,
   input  logic [DATA_W-1:0] w_data,
   output logic              w_hold,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   output logic              BVALID,
   input  logic              BREADY,
   output logic [1:0]        BRESP,
   output logic              proto_err
);

   localparam int unsigned CNT_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TMO_SAT  = CNT_W'(ACK_TIMEOUT);
   localparam logic [31:0]      DEPTH_L  = 32'(MEM_DEPTH);

   wr_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   resp_t             resp_q, resp_d;
   logic              perr_q, perr_d;

   logic              aw_acc, aw_viol, w_acc, w_viol, b_done;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] data_r;

   assign b_done = (state_q == RESP) && BREADY;

   beat_capture #(.W(ADDR_W)) u_aw_cap (
      .clk_i     (ACLK),
      .rst_ni    (ARESETn),
      .strobe_i  (aw_strobe),
      .data_i    (aw_addr),
      .release_i (b_done),
      .data_o    (addr_r),
      .hold_o    (aw_hold),
      .accept_o  (aw_acc),
      .viol_o    (aw_viol)
   );

   beat_capture #(.W(DATA_W)) u_w_cap (
      .clk_i     (ACLK),
      .rst_ni    (ARESETn),
      .strobe_i  (w_strobe),
      .data_i    (w_data),
      .release_i (b_done),
      .data_o    (data_r),
      .hold_o    (w_hold),
      .accept_o  (w_acc),
      .viol_o    (w_viol)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      perr_d  = perr_q | aw_viol | w_viol;
      case (state_q)
         IDLE: begin
            if (aw_acc && w_acc) state_d = DECODE;
            else if (aw_acc)     state_d = WAIT_W;
            else if (w_acc)      state_d = WAIT_AW;
         end
         WAIT_W:  if (w_acc)  state_d = DECODE;
         WAIT_AW: if (aw_acc) state_d = DECODE;
         DECODE: begin
            cnt_d = '0;
            if (32'(addr_r) < DEPTH_L) begin
               state_d = MEM_WR;
            end else begin
               resp_d  = SLVERR;
               state_d = RESP;
            end
         end
         MEM_WR: begin
            // cnt_q counts ack-less cycles already spent; an ack in the final
            // allowed cycle wins over the timeout.
            if (mem_ack) begin
               resp_d  = OKAY;
               state_d = RESP;
            end else if (cnt_q >= TMO_LAST) begin
               resp_d  = SLVERR;
               cnt_d   = TMO_SAT;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP:    if (BREADY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         resp_q  <= OKAY;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         perr_q  <= perr_d;
      end
   end

   assign mem_we    = (state_q == MEM_WR);
   assign mem_addr  = addr_r;
   assign mem_wdata = data_r;
   assign BVALID    = (state_q == RESP);
   assign BRESP     = resp_q;
   assign proto_err = perr_q;

endmodule

// File: tb/tb_axi_lite_wr_ctrl.sv
module tb_axi_lite_wr_ctrl;

   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned TMO   = 15;

   logic          ACLK = 1'b0;
   logic          ARESETn = 1'b1;
   logic          aw_strobe = 1'b0;
   logic [AW-1:0] aw_addr = '0;
   logic          aw_hold;
   logic          w_strobe = 1'b0;
   logic [DW-1:0] w_data = '0;
   logic          w_hold;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack = 1'b0;
   logic          BVALID;
   logic          BREADY = 1'b0;
   logic [1:0]    BRESP;
   logic          proto_err;

   axi_lite_wr_ctrl #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .MEM_DEPTH   (DEPTH),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .aw_strobe (aw_strobe),
      .aw_addr   (aw_addr),
      .aw_hold   (aw_hold),
      .w_strobe  (w_strobe),
      .w_data    (w_data),
      .w_hold    (w_hold),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .BVALID    (BVALID),
      .BREADY    (BREADY),
      .BRESP     (BRESP),
      .proto_err (proto_err)
   );

   initial forever #5 ACLK = ~ACLK;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      int         cycles;
   } wr_exp_t;

   wr_exp_t    wq[$];
   logic [1:0] rq[$];
   int         nvec = 0;
   int         nerr = 0;
   int         ack_at = 0;
   bit         proto_exp = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory succeeds only if its ack lands within the allowed window.
   function automatic bit ack_ok(input int a);
      return (a >= 1) && (a <= int'(TMO));
   endfunction

   // Memory model: raises mem_ack in the ack_at-th cycle of a write request.
   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge ACLK);
         if (mem_we === 1'b1) begin
            c++;
            mem_ack = (c == ack_at);
         end else begin
            c = 0;
            mem_ack = 1'b0;
         end
      end
   end

   // Monitor: checks writes and B responses against the scoreboard queues.
   initial begin
      int         burst;
      bit         inb;
      int         expc;
      wr_exp_t    e;
      burst = 0;
      inb   = 1'b0;
      expc  = 0;
      forever begin
         @(negedge ACLK);
         #1;
         if (ARESETn !== 1'b1) begin
            inb   = 1'b0;
            burst = 0;
         end else begin
            if (mem_we === 1'b1) begin
               if (!inb) begin
                  inb   = 1'b1;
                  burst = 1;
                  if (wq.size() == 0) begin
                     nvec++;
                     nerr++;
                     expc = 0;
                     $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
                  end else begin
                     e = wq.pop_front();
                     chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                     chk("wr_data", 32'(mem_wdata), 32'(e.data));
                     expc = e.cycles;
                  end
               end else begin
                  burst++;
               end
            end else if (inb) begin
               inb = 1'b0;
               chk("we_cycles", burst, expc);
            end
            if (BVALID === 1'b1 && BREADY === 1'b1) begin
               if (rq.size() == 0) begin
                  nvec++;
                  nerr++;
                  $display("FAIL unexpected_bresp: got %0h expected no response", BRESP);
               end else begin
                  chk("bresp", 32'(BRESP), 32'(rq.pop_front()));
               end
            end
         end
      end
   end

   task automatic reset_pulse();
      @(negedge ACLK);
      #2 ARESETn = 1'b0;
      #1;
      chk("reset_outputs", {aw_hold, w_hold, mem_we, BVALID, proto_err, BRESP, mem_addr, mem_wdata}, '0);
      aw_strobe = 1'b0;
      w_strobe  = 1'b0;
      BREADY    = 1'b0;
      wq.delete();
      rq.delete();
      proto_exp = 1'b0;
      @(negedge ACLK);
      #2 ARESETn = 1'b1;
   endtask

   // mode 0: AW and W together; 1: AW first; 2: W first (gap cycles apart).
   // extra 1/2: stray AW/W strobe while the response is stalled.
   task automatic send(input logic [7:0] a, input logic [7:0] d, input int mode,
                       input int gap, input int ack, input int bdly, input int extra);
      bit         in_rng;
      int         cyc;
      int         exp_lat;
      int         k;
      logic [1:0] exp_resp;
      wr_exp_t    e;
      in_rng   = (a < DEPTH);
      cyc      = ack_ok(ack) ? ack : int'(TMO);
      exp_resp = (in_rng && ack_ok(ack)) ? 2'b00 : 2'b10;
      exp_lat  = in_rng ? 2 + cyc : 2;
      if (in_rng) begin
         e.addr = a; e.data = d; e.cycles = cyc;
         wq.push_back(e);
      end
      rq.push_back(exp_resp);
      ack_at = ack;

      @(negedge ACLK);
      if (mode == 0) begin
         aw_strobe = 1'b1; aw_addr = a;
         w_strobe  = 1'b1; w_data  = d;
      end else begin
         if (mode == 1) begin aw_strobe = 1'b1; aw_addr = a; end
         else           begin w_strobe  = 1'b1; w_data  = d; end
         for (int i = 1; i <= gap; i++) begin
            @(negedge ACLK);
            aw_strobe = 1'b0; w_strobe = 1'b0;
            if (mode == 1) aw_addr = 8'($urandom);
            else           w_data  = 8'($urandom);
            chk("wait_holds", {aw_hold, w_hold}, (mode == 1) ? 2'b10 : 2'b01);
            chk("wait_idle_outs", {mem_we, BVALID}, 2'b00);
         end
         if (mode == 1) begin w_strobe  = 1'b1; w_data  = d; end
         else           begin aw_strobe = 1'b1; aw_addr = a; end
      end
      @(negedge ACLK);
      aw_strobe = 1'b0; w_strobe = 1'b0;
      aw_addr = 8'($urandom); w_data = 8'($urandom);

      k = 1;
      while (BVALID !== 1'b1 && k < 60) begin
         @(negedge ACLK);
         k++;
      end
      chk("latency", k, exp_lat);
      if (BVALID !== 1'b1) begin
         reset_pulse();
         return;
      end

      for (int i = 0; i < bdly; i++) begin
         if (i == 0 && extra == 1) begin aw_strobe = 1'b1; aw_addr = 8'($urandom); proto_exp = 1'b1; end
         if (i == 0 && extra == 2) begin w_strobe  = 1'b1; w_data  = 8'($urandom); proto_exp = 1'b1; end
         @(negedge ACLK);
         aw_strobe = 1'b0; w_strobe = 1'b0;
         chk("stall_bvalid", 32'(BVALID), 32'd1);
         chk("stall_bresp", 32'(BRESP), 32'(exp_resp));
         chk("stall_holds", {aw_hold, w_hold}, 2'b11);
      end
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
      chk("post_b_bvalid", 32'(BVALID), 32'd0);
      chk("post_b_holds", {aw_hold, w_hold}, 2'b00);
      chk("proto_err", 32'(proto_err), 32'(proto_exp));
   endtask

   initial begin
      logic [7:0] a;
      int         r, ack, bdly, extra;

      #1 ARESETn = 1'b0;
      #1;
      chk("reset_state", {aw_hold, w_hold, mem_we, BVALID, proto_err, BRESP, mem_addr, mem_wdata}, '0);
      @(negedge ACLK);
      @(negedge ACLK);
      #2 ARESETn = 1'b1;

      send(8'h03, 8'hA5, 0, 0, 1, 0, 0);
      send(8'h07, 8'h5A, 2, 4, 1, 0, 0);
      send(8'h20, 8'h11, 0, 0, 1, 0, 0);
      send(8'h0F, 8'h22, 1, 1, 2, 0, 0);
      send(8'h10, 8'h44, 2, 2, 1, 0, 0);
      send(8'h05, 8'hC3, 0, 0, 0, 0, 0);
      send(8'h06, 8'h3C, 0, 0, TMO, 0, 0);
      send(8'h08, 8'h3D, 0, 0, TMO + 1, 0, 0);
      send(8'h09, 8'h77, 1, 2, 2, 5, 1);
      send(8'h0B, 8'h78, 0, 0, 1, 1, 0);

      // Reset in the middle of a stalled memory write.
      ack_at = 0;
      wq.push_back('{addr: 8'h0A, data: 8'h33, cycles: int'(TMO)});
      rq.push_back(2'b10);
      @(negedge ACLK);
      aw_strobe = 1'b1; aw_addr = 8'h0A; w_strobe = 1'b1; w_data = 8'h33;
      @(negedge ACLK);
      aw_strobe = 1'b0; w_strobe = 1'b0;
      repeat (3) @(negedge ACLK);
      chk("mid_memwr_we", 32'(mem_we), 32'd1);
      reset_pulse();
      r = 0;
      repeat (3) begin
         @(negedge ACLK);
         r = r | int'(BVALID) | int'(mem_we);
      end
      chk("no_resp_after_reset", r, 0);
      send(8'h0C, 8'h96, 0, 0, 1, 0, 0);

      for (int n = 0; n < 40; n++) begin
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
         r = int'($urandom_range(0, 9));
         if (r == 0)      ack = 0;
         else if (r == 1) ack = int'(TMO);
         else if (r == 2) ack = int'(TMO) + 1;
         else             ack = int'($urandom_range(1, 6));
         bdly  = int'($urandom_range(0, 3));
         extra = (bdly > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         send(a, 8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), ack, bdly, extra);
      end

      repeat (3) @(negedge ACLK);
      chk("wq_drained", wq.size(), 0);
      chk("rq_drained", rq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axi_lite_wr_ctrl.md
Name: axi_lite_wr_ctrl

Overview:
Write-transaction sequencer for the AXI-Lite slave. It sits above two receive-channel latches, AW (address) and W (data). It pairs one AW beat with one W beat, issues a single write to the slave's register/memory array, and returns the B response. It also back-pressures both receive latches through their hold inputs while a transaction is in flight.

Parameters:
ADDR_W, 8, width of AW address.
DATA_W, 8, width of W data and memory word.
MEM_DEPTH, 16, number of valid word addresses (0..MEM_DEPTH-1); must be ≤ 2**ADDR_W.
ACK_TIMEOUT, 15, max cycles to wait for mem_ack before aborting with SLVERR; ≥1.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESETn  in  1  asynchronous active-low reset.
aw_strobe  in  1  one-cycle pulse: AW latch captured a beat this cycle.
aw_addr  in  ADDR_W  latched AW address, valid from aw_strobe cycle.
aw_hold  out  1  hold AW latch (its READY low) while 1.
w_strobe  in  1  one-cycle pulse: W latch captured a beat.
w_data  in  DATA_W  latched W data.
w_hold  out  1  hold W latch while 1.
mem_we  out  1  write request to memory, held until mem_ack or timeout.
mem_addr  out  ADDR_W  write address.
mem_wdata  out  DATA_W  write data.
mem_ack  in  1  memory accepted the write (sampled while mem_we=1).
BVALID  out  1  write response valid.
BREADY  in  1  master ready for response.
BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
proto_err  out  1  sticky: strobe received while that channel was held; cleared only by reset.

Behaviour:
- Reset (async, ARESETn=0): state=IDLE. aw_hold, w_hold, mem_we, BVALID and proto_err are 0. BRESP, mem_addr, mem_wdata and internal regs are 0. Reset mid-transaction aborts it; no response is issued afterwards.
- Capture: on aw_strobe, register aw_addr and set aw_hold=1 from the next cycle. On w_strobe, register w_data and set w_hold=1. Each hold stays 1 until the B handshake completes.
- States:
  - IDLE: both strobes in the same cycle → DECODE. aw only → WAIT_W. w only → WAIT_AW.
  - WAIT_W: on w_strobe → DECODE.
  - WAIT_AW: on aw_strobe → DECODE.
  - DECODE (1 cycle): addr < MEM_DEPTH → MEM_WR, timeout counter cleared. Otherwise → RESP with BRESP=SLVERR and no memory access.
  - MEM_WR: mem_we=1 with the registered addr/data. On mem_ack → RESP with OKAY; mem_we drops the same cycle state leaves. Counter increments each cycle without ack; if the counter reaches ACK_TIMEOUT without ack → RESP with SLVERR. An ack in the cycle the counter equals ACK_TIMEOUT counts as success (OKAY).
  - RESP: BVALID=1, BRESP stable. On BVALID&&BREADY → IDLE. aw_hold and w_hold clear on the next edge, together with BVALID.
- Latency, both strobes in the same cycle with an in-range address and mem_ack in the first MEM_WR cycle: BVALID asserts 3 cycles after the strobe edge (DECODE, MEM_WR, RESP).
- Strobes arriving in a cycle where the corresponding hold=1 are ignored and set proto_err. A strobe on a channel already captured but not yet held (same-cycle hold rise) cannot occur, because hold rises on the cycle after the strobe. A second strobe in that window counts as a violation.
- BVALID, once asserted, does not drop until BREADY. BRESP does not change while BVALID=1.
- Timeout counter width: $clog2(ACK_TIMEOUT+1); saturates, never wraps.

Decomposition:
- Shared package axi_pkg: typedef resp_t (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and wr_state_t {IDLE, WAIT_W, WAIT_AW, DECODE, MEM_WR, RESP}. Reused by the future read controller.
- One natural sub-module: beat_capture (strobe → data register + hold flag + violation detect), instantiated twice, for AW and W.

Test Plan:
- AW addr=8'h03 and W data=8'hA5 strobed in the same cycle, mem_ack in the first MEM_WR cycle, BREADY=1 → mem_we one cycle with addr 03 / data A5. BVALID 3 cycles after the strobe, BRESP=00. Holds clear one cycle after the handshake.
- W strobe (8'h5A) first, AW (8'h07) 4 cycles later → state WAIT_AW, w_hold=1 throughout the wait. Write of 5A to 07, then OKAY.
- AW addr=8'h20 (≥ MEM_DEPTH) → mem_we never asserts, BRESP=10 one cycle after DECODE.
- mem_ack held 0 → mem_we high for ACK_TIMEOUT cycles, then BRESP=10. Repeat with ack on exactly cycle ACK_TIMEOUT → BRESP=00.
- BREADY low for 5 cycles in RESP → BVALID and BRESP stable, holds stay 1. Extra aw_strobe during RESP → ignored, proto_err=1 sticky.
- ARESETn pulsed low during MEM_WR → all outputs 0 immediately. After release, a fresh transaction completes normally.
